// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV32I front end.
//   XLEN_C        - datapath width (PC and instruction word)
//   NOP_INSTR_C   - addi x0,x0,0, the canonical bubble
//   fetch_state_t - fetch FSM states
//   if_id_t       - IF/ID pipeline register payload
//   word_align    - clears the two low address bits
package riscv_pkg;

   localparam int unsigned XLEN_C = 32;
   localparam logic [XLEN_C-1:0] NOP_INSTR_C = 32'h0000_0013;

   typedef enum logic [1:0] {
      ISSUE = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN_C-1:0] instr;
      logic [XLEN_C-1:0] pc;
      logic [XLEN_C-1:0] pc_plus4;
   } if_id_t;

   function automatic logic [XLEN_C-1:0] word_align(input logic [XLEN_C-1:0] addr);
      return addr & ~XLEN_C'(3);
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: generic IF/ID-style pipeline register with load, hold, flush and valid.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset
//   load_i            - capture {instr_i, pc_i, pc_plus4_i} and mark valid
//   flush_i           - kill the held entry (highest priority after reset)
//   stall_i           - downstream cannot consume; a valid entry is held
//   instr_i, pc_i, pc_plus4_i - incoming payload
//   valid_o           - entry is live
//   instr_o, pc_o, pc_plus4_o - held payload; instr_o is NOP_INSTR when not valid
module if_id_reg
   import riscv_pkg::*;
#(
   parameter logic [XLEN_C-1:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              flush_i,
   input  logic              stall_i,
   input  logic [XLEN_C-1:0] instr_i,
   input  logic [XLEN_C-1:0] pc_i,
   input  logic [XLEN_C-1:0] pc_plus4_i,
   output logic              valid_o,
   output logic [XLEN_C-1:0] instr_o,
   output logic [XLEN_C-1:0] pc_o,
   output logic [XLEN_C-1:0] pc_plus4_o
);

   logic   valid_q, valid_d;
   if_id_t data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d      = 1'b0;
         data_d.instr = NOP_INSTR;
      end else if (load_i) begin
         valid_d         = 1'b1;
         data_d.instr    = instr_i;
         data_d.pc       = pc_i;
         data_d.pc_plus4 = pc_plus4_i;
      end else if (valid_q && !stall_i) begin
         // Consumed with nothing new behind it: become a bubble.
         valid_d      = 1'b0;
         data_d.instr = NOP_INSTR;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q         <= 1'b0;
         data_q.instr    <= NOP_INSTR;
         data_q.pc       <= '0;
         data_q.pc_plus4 <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o    = valid_q;
   assign instr_o    = data_q.instr;
   assign pc_o       = data_q.pc;
   assign pc_plus4_o = data_q.pc_plus4;

endmodule

// File: rtl/if_stage.sv
// if_stage: RV32I instruction fetch. Owns the PC, runs a single-outstanding
// request/response handshake to instruction memory and feeds the IF/ID register.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   imem_req, imem_addr      - one-cycle fetch request and its address
//   imem_rvalid, imem_rdata  - memory response strobe and instruction word
//   stall                    - decode cannot accept a new instruction
//   redirect, redirect_pc    - taken branch/jump: flush and refetch at target
//   id_valid, id_instr, id_pc, id_pc_plus4 - IF/ID register outputs
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_bubble_cnt.
module if_stage
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN      = XLEN_C,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_bubble_cnt
`endif
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            discard_q, discard_d;
   logic [XLEN-1:0] skid_q, skid_d;
   logic [XLEN-1:0] pc_plus4;
   logic            accept;
   logic            load;
   logic [XLEN-1:0] load_instr;

   assign pc_plus4 = pc_q + XLEN'(4);
   assign accept   = !stall || !id_valid;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      discard_d  = discard_q;
      skid_d     = skid_q;
      load       = 1'b0;
      load_instr = imem_rdata;
      unique case (state_q)
         ISSUE: begin
            state_d = WAIT;
            // The request going out this cycle belongs to the old path.
            if (redirect) discard_d = 1'b1;
         end
         WAIT: begin
            if (redirect) begin
               if (imem_rvalid) begin
                  state_d   = ISSUE;
                  discard_d = 1'b0;
               end else begin
                  discard_d = 1'b1;
               end
            end else if (imem_rvalid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = ISSUE;
               end else if (accept) begin
                  load    = 1'b1;
                  pc_d    = pc_plus4;
                  state_d = ISSUE;
               end else begin
                  skid_d  = imem_rdata;
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            // pc_q is unchanged while holding, so it is the skid word's PC.
            if (redirect) begin
               state_d = ISSUE;
            end else if (!stall) begin
               load       = 1'b1;
               load_instr = skid_q;
               pc_d       = pc_plus4;
               state_d    = ISSUE;
            end
         end
         default: state_d = ISSUE;
      endcase
      if (redirect) pc_d = word_align(redirect_pc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ISSUE;
         pc_q      <= RESET_PC;
         discard_q <= 1'b0;
         skid_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
         skid_q    <= skid_d;
      end
   end

   // Gated by rst so no request escapes while the stage is held in reset.
   assign imem_req  = (state_q == ISSUE) && !rst;
   assign imem_addr = pc_q;

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (load),
      .flush_i    (redirect),
      .stall_i    (stall),
      .instr_i    (load_instr),
      .pc_i       (pc_q),
      .pc_plus4_i (pc_plus4),
      .valid_o    (id_valid),
      .instr_o    (id_instr),
      .pc_o       (id_pc),
      .pc_plus4_o (id_pc_plus4)
   );

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_q;
   logic [31:0] perf_bubble_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q  <= '0;
         perf_bubble_q <= '0;
      end else begin
         if (load)      perf_fetch_q  <= perf_fetch_q + 32'd1;
         if (!id_valid) perf_bubble_q <= perf_bubble_q + 32'd1;
      end
   end

   assign perf_fetch_cnt  = perf_fetch_q;
   assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule
